seq_multiplier: RTL and testbench

//   Multi-cycle shift-add 32x32 multiplier; the producer side of the 64-bit product bus consumed by the Hi/Lo register pair.

---
 rtl/seq_multiplier_if.sv | 23 ++
 rtl/seq_multiplier.sv | 102 ++++++++++
 tb/tb_seq_multiplier.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the EX stage and the shift-add multiplier.
// The slave side is the multiplier. The master side is the issuing stage.
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [5:0]         Signal;
    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic [2*WIDTH-1:0] multAns;
    logic               busy;
    logic               done;

    modport master (
        output start, Signal, dataA, dataB,
        input  multAns, busy, done
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output multAns, busy, done
    );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier for MULT/MULTU. It retires one multiplier bit per clock.
// The {hi,lo} product is registered and announced by a one-cycle done pulse.
module seq_multiplier #(
    parameter int         WIDTH = 32,
    parameter logic [5:0] MULT  = 6'd24,
    parameter logic [5:0] MULTU = 6'd25
) (
    input  logic              clk,
    input  logic              reset,
    seq_multiplier_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state,    w_state_next;
    logic [CW-1:0]      r_count,    w_count_next;
    logic [2*WIDTH-1:0] r_acc,      w_acc_next;
    logic [WIDTH-1:0]   r_mcand,    w_mcand_next;
    logic [WIDTH-1:0]   r_mplier,   w_mplier_next;
    logic               r_sign,     w_sign_next;
    logic [2*WIDTH-1:0] r_mult_ans, w_mult_ans_next;

    logic               w_is_signed;
    logic               w_accept;
    logic [WIDTH:0]     w_sum;

    assign w_is_signed = (bus.Signal == MULT);
    assign w_accept    = bus.start && ((bus.Signal == MULT) || (bus.Signal == MULTU));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_sign     <= 1'b0;
            r_mult_ans <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_acc      <= w_acc_next;
            r_mcand    <= w_mcand_next;
            r_mplier   <= w_mplier_next;
            r_sign     <= w_sign_next;
            r_mult_ans <= w_mult_ans_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_acc_next      = r_acc;
        w_mcand_next    = r_mcand;
        w_mplier_next   = r_mplier;
        w_sign_next     = r_sign;
        w_mult_ans_next = r_mult_ans;
        w_sum           = '0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Magnitudes are kept unsigned, so abs(-2^WIDTH-1) becomes +2^WIDTH-1.
                    w_mcand_next  = (w_is_signed && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
                    w_mplier_next = (w_is_signed && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
                    w_sign_next   = w_is_signed && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
                    w_acc_next    = '0;
                    w_count_next  = CW'(WIDTH);
                    w_state_next  = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count != '0) begin
                    w_sum         = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                                  + (r_mplier[0] ? {1'b0, r_mcand} : '0);
                    w_acc_next    = {w_sum, r_acc[WIDTH-1:1]};
                    w_mplier_next = r_mplier >> 1;
                    w_count_next  = r_count - 1'b1;
                end else begin
                    // Sign fix-up is folded into the cycle that loads the output register.
                    w_mult_ans_next = r_sign ? -r_acc : r_acc;
                    w_state_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.multAns = r_mult_ans;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier.
// Expected products are queued at issue time and popped by an independent done monitor.
module tb_seq_multiplier;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam int         LAT     = 33;

    logic clk;
    logic reset;

    seq_multiplier_if #(.WIDTH(32)) mif ();

    seq_multiplier #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued product.
    always @(negedge clk) begin
        if (!reset && mif.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got=%h expected=no_done", mif.multAns);
            end else begin
                chk("product", mif.multAns, exp_q.pop_front());
            end
        end
    end

    // Called at a negedge in IDLE; returns at the negedge after the acceptance edge.
    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        mif.start  = 1'b1;
        mif.Signal = fn;
        mif.dataA  = a;
        mif.dataB  = b;
        @(negedge clk);
        mif.start  = 1'b0;
        chk("busy_after_accept", 64'(mif.busy), 64'd1);
    endtask

    // j0 = edges already elapsed since acceptance; returns at the negedge of the done cycle.
    task automatic wait_done(input int j0, output int lat);
        lat = j0;
        while (!mif.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!mif.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=%0d expected=%0d", lat, LAT);
        end
    endtask

    task automatic do_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        int lat;
        exp_q.push_back(exp);
        issue(fn, a, b);
        wait_done(0, lat);
        chk("latency", 64'(lat), 64'(LAT));
        @(negedge clk);
        chk("busy_after_done", 64'(mif.busy), 64'd0);
    endtask

    initial begin
        int lat;
        int done_seen;
        reset      = 1'b1;
        mif.start  = 1'b0;
        mif.Signal = '0;
        mif.dataA  = '0;
        mif.dataB  = '0;
        repeat (3) @(negedge clk);
        chk("reset_multAns", mif.multAns, 64'd0);
        chk("reset_busy", 64'(mif.busy), 64'd0);
        chk("reset_done", 64'(mif.done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(F_MULTU, 32'd3, 32'd5, 64'd15);
        do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        do_op(F_MULT, -32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
        do_op(F_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        // Unsupported funct code must leave everything untouched.
        mif.start  = 1'b1;
        mif.Signal = 6'd26;
        mif.dataA  = 32'd9;
        mif.dataB  = 32'd9;
        @(negedge clk);
        mif.start = 1'b0;
        chk("bad_funct_busy", 64'(mif.busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("bad_funct_busy_later", 64'(mif.busy), 64'd0);
        chk("bad_funct_hold", mif.multAns, 64'h4000_0000_0000_0000);

        // Reset at RUN cycle 10 aborts without a done pulse.
        issue(F_MULTU, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_multAns", mif.multAns, 64'd0);
        chk("abort_busy", 64'(mif.busy), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        do_op(F_MULTU, 32'd2, 32'd2, 64'd4);

        // Reset and start together: reset wins.
        reset      = 1'b1;
        mif.start  = 1'b1;
        mif.Signal = F_MULTU;
        mif.dataA  = 32'd7;
        mif.dataB  = 32'd7;
        @(negedge clk);
        reset     = 1'b0;
        mif.start = 1'b0;
        chk("reset_start_busy", 64'(mif.busy), 64'd0);
        @(negedge clk);
        chk("reset_start_busy_later", 64'(mif.busy), 64'd0);

        // A start during RUN is dropped; the next start right after done is taken.
        exp_q.push_back(64'd7006652);
        issue(F_MULTU, 32'd1234, 32'd5678);
        repeat (4) @(negedge clk);
        mif.start  = 1'b1;
        mif.Signal = F_MULTU;
        mif.dataA  = 32'd100;
        mif.dataB  = 32'd100;
        chk("hold_during_run", mif.multAns, 64'd0);
        @(negedge clk);
        mif.start = 1'b0;
        wait_done(5, lat);
        chk("latency_ignored_start", 64'(lat), 64'(LAT));
        @(negedge clk);
        do_op(F_MULT, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
